barrido_rtc: RTL and testbench
==============================

Name: barrido_rtc

Overview:
Autonomous scan sequencer placed upstream of the RTC interface module. It drives that module's PicoBlaze-style port (chipsel, readstrobe, writestrobe, address, data) instead of the processor. On each refresh tick it reads the six time/date registers of the RTC chip and commits them as one atomic BCD snapshot for the display logic. It also forwards single-register user writes (clock setting), serialised against the scan.

Parameters:
DIR_BASE, 8'h21, address of the first register read (seconds); registers DIR_BASE..DIR_BASE+5 = sec, min, hour, day, month, year.
ESPERA, 100, clock cycles waited after each strobe before the interface result is valid (covers the full external bus cycle); 8-bit counter, legal range 2..255.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
tick  in  1  one-cycle refresh request (e.g. 1 Hz enable)
wr_req  in  1  one-cycle user write request
wr_dir  in  8  user write address
wr_dato  in  8  user write data
data_in_micro  in  8  read data returned by the RTC interface
chipsel  out  1  select to RTC interface
readstrobe  out  1  read strobe to RTC interface
writestrobe  out  1  write strobe to RTC interface
dir_out  out  8  address to RTC interface
dato_out  out  8  write data to RTC interface
seg, min, hora, dia, mes, anio  out  8 each  committed BCD snapshot
valido  out  1  one-cycle pulse when a new snapshot is committed
ocupado  out  1  high while any scan or write is in progress
wr_ack  out  1  one-cycle pulse when a user write completes
error  out  1  sticky BCD error flag (only with BCD_CHECK_EN; otherwise constant 0)

Behaviour:
- Reset (async, any state): FSM to REPOSO; all outputs 0; snapshot, shadow registers, pending flags and counters cleared. A scan or write in progress is abandoned with no commit and no wr_ack.
- States: REPOSO, LEE_PULSO, LEE_ESPERA, LEE_CAPTURA, ESC_PULSO, ESC_ESPERA, COMMIT.
- Pending flags: tick sets pend_lec; wr_req sets pend_esc and latches wr_dir/wr_dato. Each flag is one deep: repeated ticks while pending are dropped, and a new wr_req while pend_esc=1 overwrites the latched address/data (last write wins).
- REPOSO: if pend_esc go to ESC_PULSO (writes have priority); else if pend_lec clear it, set index i=0 and go to LEE_PULSO. Same-cycle tick and wr_req: both latched, write served first.
- LEE_PULSO (1 cycle): chipsel=1, readstrobe=1, dir_out=DIR_BASE+i; go to LEE_ESPERA with count=0.
- LEE_ESPERA: chipsel=1, strobes 0, dir_out held; count increments; at count=ESPERA-1 go to LEE_CAPTURA.
- LEE_CAPTURA (1 cycle): shadow[i] <= data_in_micro; if i=5 go to COMMIT, else i+1 and back to LEE_PULSO.
- COMMIT (1 cycle): copy all six shadow registers to the outputs in the same edge; valido=1; go to REPOSO.
- ESC_PULSO (1 cycle): chipsel=1, writestrobe=1, dir_out=wr_dir latched, dato_out=wr_dato latched; clear pend_esc; go to ESC_ESPERA.
- ESC_ESPERA: same count rule as reads; on exit wr_ack=1 and go to REPOSO.
- A scan is never interrupted by a write: a write arriving mid-scan waits for COMMIT.
- ocupado=1 in every state except REPOSO.
- dir_out and dato_out hold their last values in REPOSO; chipsel=0 in REPOSO.
- Per-register read latency: 1+ESPERA+1 cycles. Scan latency from REPOSO to valido: 6*(ESPERA+2)+1 cycles.
- Address arithmetic is 8-bit unsigned and wraps modulo 256.

Optional Feature:
BCD_CHECK_EN:
- Defined: in COMMIT, every nibble of the six shadow registers is checked for values <=9. Hour tens digit must be <=2; month must be 01..12. On any violation the snapshot is not updated, valido stays 0, and error is set to 1 (sticky until reset).
- Undefined: no check; every completed scan commits; error is tied to 0.

Test Plan:
- Reset released, ESPERA=4, one tick, interface returns 0x45,0x59,0x23,0x31,0x12,0x16 for 0x21..0x26 -> exactly one valido pulse 37 cycles after REPOSO; seg=0x45 … anio=0x16; six readstrobe pulses at addresses 0x21..0x26.
- wr_req with wr_dir=0x22, wr_dato=0x30 in the same cycle as tick -> writestrobe with dir_out=0x22 and dato_out=0x30 precedes the first readstrobe; wr_ack comes 5 cycles after the strobe, then the scan runs.
- Three ticks during one scan -> exactly one further scan after COMMIT, giving two valido pulses in total.
- reset asserted during LEE_ESPERA of register 3 -> all outputs 0 immediately, no valido; the next tick restarts at address 0x21.
- BCD_CHECK_EN defined, minute register returns 0x5A -> outputs keep the previous snapshot, valido=0, error=1 and stays 1 after later good scans.

Source files
------------

// File: rtl/barrido_rtc.sv
`default_nettype none
// ============================================================================
//  Module      : barrido_rtc
//  Description : Autonomous scan sequencer in front of the RTC interface.
//                On each refresh tick it reads the six time/date registers
//                (sec, min, hour, day, month, year) through the interface's
//                PicoBlaze-style port and commits them as one atomic BCD
//                snapshot. Single-register user writes are forwarded and
//                serialised against the scan (writes win when both wait).
//                Optional build macro: BCD_CHECK_EN (validate the snapshot
//                before committing; raise a sticky error flag on bad data).
//  Revision    : 1.0 - initial release
// ============================================================================
module barrido_rtc #(
    parameter logic [7:0]  DIR_BASE = 8'h21,  // address of the seconds register
    parameter int unsigned ESPERA   = 100     // wait cycles after each strobe (2..255)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       wr_req,
    input  logic [7:0] wr_dir,
    input  logic [7:0] wr_dato,
    input  logic [7:0] data_in_micro,
    output logic       chipsel,
    output logic       readstrobe,
    output logic       writestrobe,
    output logic [7:0] dir_out,
    output logic [7:0] dato_out,
    output logic [7:0] seg,
    output logic [7:0] min,
    output logic [7:0] hora,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] anio,
    output logic       valido,
    output logic       ocupado,
    output logic       wr_ack,
    output logic       error
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] S_REPOSO      = 3'd0;
    localparam logic [2:0] S_LEE_PULSO   = 3'd1;
    localparam logic [2:0] S_LEE_ESPERA  = 3'd2;
    localparam logic [2:0] S_LEE_CAPTURA = 3'd3;
    localparam logic [2:0] S_ESC_PULSO   = 3'd4;
    localparam logic [2:0] S_ESC_ESPERA  = 3'd5;
    localparam logic [2:0] S_COMMIT      = 3'd6;

    // Last value of the wait counter: the wait phase lasts exactly ESPERA cycles
    localparam logic [7:0] c_CNT_FIN = 8'(ESPERA - 1);
    // Index of the last register in a scan (year)
    localparam logic [2:0] c_IDX_ULT = 3'd5;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [2:0] r_state;
    logic [2:0] w_next;

    logic       r_pend_lec;       // scan requested, not yet started
    logic       r_pend_esc;       // user write requested, not yet strobed
    logic [7:0] r_wr_dir;         // latched user write address (last wins)
    logic [7:0] r_wr_dato;        // latched user write data (last wins)

    logic [2:0] r_idx;            // register index within the scan (0..5)
    logic [7:0] r_cnt;            // wait-phase counter
    logic [7:0] r_shadow [0:5];   // registers read so far in the current scan

    logic [7:0] r_dir_hold;       // address presented during waits / idle
    logic [7:0] r_dato_hold;      // data presented outside write strobes

    logic [7:0] r_seg;
    logic [7:0] r_min;
    logic [7:0] r_hora;
    logic [7:0] r_dia;
    logic [7:0] r_mes;
    logic [7:0] r_anio;
    logic       r_valido;
    logic       r_wr_ack;

    logic       w_lec_pend;       // scan pending, including a tick arriving now
    logic       w_esc_pend;       // write pending, including a request arriving now
    logic       w_cnt_fin;
    logic       w_inicio_lec;     // REPOSO is starting a scan this cycle
    logic       w_bcd_ok;

    logic       w_chipsel;
    logic       w_readstrobe;
    logic       w_writestrobe;
    logic [7:0] w_dir_out;
    logic [7:0] w_dato_out;

    // A request arriving while idle is served without an extra idle cycle
    assign w_lec_pend   = r_pend_lec | tick;
    assign w_esc_pend   = r_pend_esc | wr_req;
    assign w_cnt_fin    = (r_cnt == c_CNT_FIN);
    assign w_inicio_lec = (r_state == S_REPOSO) && !w_esc_pend && w_lec_pend;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_REPOSO;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM: next-state logic; writes have priority, a running scan is never cut
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_REPOSO: begin
                if (w_esc_pend) begin
                    w_next = S_ESC_PULSO;
                end else if (w_lec_pend) begin
                    w_next = S_LEE_PULSO;
                end
            end
            S_LEE_PULSO:   w_next = S_LEE_ESPERA;
            S_LEE_ESPERA: begin
                if (w_cnt_fin) begin
                    w_next = S_LEE_CAPTURA;
                end
            end
            S_LEE_CAPTURA: begin
                if (r_idx == c_IDX_ULT) begin
                    w_next = S_COMMIT;
                end else begin
                    w_next = S_LEE_PULSO;
                end
            end
            S_COMMIT:      w_next = S_REPOSO;
            S_ESC_PULSO:   w_next = S_ESC_ESPERA;
            S_ESC_ESPERA: begin
                if (w_cnt_fin) begin
                    w_next = S_REPOSO;
                end
            end
            default:       w_next = S_REPOSO;
        endcase
    end

    // FSM: bus outputs towards the RTC interface, decoded from the state
    always_comb begin
        w_chipsel     = 1'b0;
        w_readstrobe  = 1'b0;
        w_writestrobe = 1'b0;
        w_dir_out     = r_dir_hold;
        w_dato_out    = r_dato_hold;
        case (r_state)
            S_LEE_PULSO: begin
                w_chipsel    = 1'b1;
                w_readstrobe = 1'b1;
                w_dir_out    = DIR_BASE + {5'd0, r_idx};
            end
            S_LEE_ESPERA: begin
                w_chipsel = 1'b1;
            end
            S_ESC_PULSO: begin
                w_chipsel     = 1'b1;
                w_writestrobe = 1'b1;
                w_dir_out     = r_wr_dir;
                w_dato_out    = r_wr_dato;
            end
            S_ESC_ESPERA: begin
                w_chipsel = 1'b1;
            end
            default: begin
                w_chipsel = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------

    // Keep address/data stable through waits and idle; the write latch may be
    // overwritten by a new request during ESC_ESPERA, so it is not reused there
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dir_hold  <= 8'h00;
            r_dato_hold <= 8'h00;
        end else begin
            r_dir_hold  <= w_dir_out;
            r_dato_hold <= w_dato_out;
        end
    end

    // One-deep request flags; a newer write request replaces the latched one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_lec <= 1'b0;
            r_pend_esc <= 1'b0;
            r_wr_dir   <= 8'h00;
            r_wr_dato  <= 8'h00;
        end else begin
            if (w_inicio_lec) begin
                r_pend_lec <= 1'b0;
            end else if (tick) begin
                r_pend_lec <= 1'b1;
            end

            if (wr_req) begin
                r_pend_esc <= 1'b1;
                r_wr_dir   <= wr_dir;
                r_wr_dato  <= wr_dato;
            end else if (r_state == S_ESC_PULSO) begin
                r_pend_esc <= 1'b0;
            end
        end
    end

    // Wait counter restarts on every strobe and runs through the wait phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 8'h00;
        end else if ((r_state == S_LEE_PULSO) || (r_state == S_ESC_PULSO)) begin
            r_cnt <= 8'h00;
        end else if ((r_state == S_LEE_ESPERA) || (r_state == S_ESC_ESPERA)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Register index and shadow capture for the scan in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= 3'd0;
            for (int k = 0; k < 6; k++) begin
                r_shadow[k] <= 8'h00;
            end
        end else begin
            if (w_inicio_lec) begin
                r_idx <= 3'd0;
            end else if (r_state == S_LEE_CAPTURA) begin
                r_shadow[r_idx] <= data_in_micro;
                if (r_idx != c_IDX_ULT) begin
                    r_idx <= r_idx + 3'd1;
                end
            end
        end
    end

    // Snapshot validation: every nibble decimal, hour tens 0..2, month 01..12
`ifdef BCD_CHECK_EN
    always_comb begin
        w_bcd_ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if ((r_shadow[k][7:4] > 4'd9) || (r_shadow[k][3:0] > 4'd9)) begin
                w_bcd_ok = 1'b0;
            end
        end
        if (r_shadow[2][7:4] > 4'd2) begin
            w_bcd_ok = 1'b0;
        end
        if ((r_shadow[4] == 8'h00) || (r_shadow[4] > 8'h12)) begin
            w_bcd_ok = 1'b0;
        end
    end
`else
    assign w_bcd_ok = 1'b1;
`endif

    // Atomic snapshot commit and the one-cycle completion pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg    <= 8'h00;
            r_min    <= 8'h00;
            r_hora   <= 8'h00;
            r_dia    <= 8'h00;
            r_mes    <= 8'h00;
            r_anio   <= 8'h00;
            r_valido <= 1'b0;
            r_wr_ack <= 1'b0;
        end else begin
            r_valido <= 1'b0;
            r_wr_ack <= 1'b0;
            if ((r_state == S_COMMIT) && w_bcd_ok) begin
                r_seg    <= r_shadow[0];
                r_min    <= r_shadow[1];
                r_hora   <= r_shadow[2];
                r_dia    <= r_shadow[3];
                r_mes    <= r_shadow[4];
                r_anio   <= r_shadow[5];
                r_valido <= 1'b1;
            end
            if ((r_state == S_ESC_ESPERA) && w_cnt_fin) begin
                r_wr_ack <= 1'b1;
            end
        end
    end

`ifdef BCD_CHECK_EN
    logic r_error;

    // Sticky error: a rejected snapshot is remembered until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if ((r_state == S_COMMIT) && !w_bcd_ok) begin
            r_error <= 1'b1;
        end
    end

    assign error = r_error;
`else
    assign error = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------------
    assign chipsel     = w_chipsel;
    assign readstrobe  = w_readstrobe;
    assign writestrobe = w_writestrobe;
    assign dir_out     = w_dir_out;
    assign dato_out    = w_dato_out;
    assign seg         = r_seg;
    assign min         = r_min;
    assign hora        = r_hora;
    assign dia         = r_dia;
    assign mes         = r_mes;
    assign anio        = r_anio;
    assign valido      = r_valido;
    assign wr_ack      = r_wr_ack;
    assign ocupado     = (r_state != S_REPOSO);

endmodule
`default_nettype wire

// File: tb/tb_barrido_rtc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_barrido_rtc
//  Description : Self-checking bench for barrido_rtc. An RTC chip emulator
//                answers reads from a register array; expected snapshots,
//                strobe sequences and latencies are derived from that array
//                and from the scan timing rules (ESPERA = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_barrido_rtc;

    localparam int unsigned ESP      = 4;
    localparam int          REG_LAT  = ESP + 2;
    localparam int          SCAN_LAT = 6 * REG_LAT + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       wr_req = 1'b0;
    logic [7:0] wr_dir = 8'h00;
    logic [7:0] wr_dato = 8'h00;
    logic [7:0] data_in_micro;
    logic       chipsel, readstrobe, writestrobe;
    logic [7:0] dir_out, dato_out;
    logic [7:0] seg, min, hora, dia, mes, anio;
    logic       valido, ocupado, wr_ack, error;

    barrido_rtc #(.DIR_BASE(8'h21), .ESPERA(ESP)) dut (
        .clk(clk), .reset(reset), .tick(tick), .wr_req(wr_req),
        .wr_dir(wr_dir), .wr_dato(wr_dato), .data_in_micro(data_in_micro),
        .chipsel(chipsel), .readstrobe(readstrobe), .writestrobe(writestrobe),
        .dir_out(dir_out), .dato_out(dato_out),
        .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .anio(anio),
        .valido(valido), .ocupado(ocupado), .wr_ack(wr_ack), .error(error)
    );

    always #5 clk = ~clk;

    // RTC chip emulator: the address seen with readstrobe selects the answer
    logic [7:0] rtc_mem [0:255];
    logic [7:0] rd_addr = 8'h00;
    always @(posedge clk) if (readstrobe) rd_addr <= dir_out;
    assign data_in_micro = rtc_mem[rd_addr];

    // Event recorder (bus strobes, pulses), stamped with the cycle number
    typedef struct { int t; bit wr; logic [7:0] a; logic [7:0] d; } ev_t;
    ev_t evq[$];
    int  valq[$];
    int  ackq[$];
    int  cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (readstrobe)  evq.push_back('{t: cyc, wr: 1'b0, a: dir_out, d: dato_out});
        if (writestrobe) evq.push_back('{t: cyc, wr: 1'b1, a: dir_out, d: dato_out});
        if (valido) valq.push_back(cyc);
        if (wr_ack) ackq.push_back(cyc);
    end

    int n_cmp = 0;
    int n_bad = 0;

    wire [47:0] snap = {seg, min, hora, dia, mes, anio};

    // Reference: a committed snapshot is the chip's six registers from 0x21 up
    function automatic logic [47:0] chip_regs();
        return {rtc_mem[8'h21], rtc_mem[8'h22], rtc_mem[8'h23],
                rtc_mem[8'h24], rtc_mem[8'h25], rtc_mem[8'h26]};
    endfunction

    function automatic logic [7:0] rand_bcd(int lo, int hi);
        int v;
        v = int'($urandom_range(hi, lo));
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic load_chip(input logic [47:0] v);
        for (int k = 0; k < 6; k++) rtc_mem[8'h21 + k] = v[47 - 8*k -: 8];
    endtask

    task automatic clear_log();
        evq.delete();
        valq.delete();
        ackq.delete();
    endtask

    task automatic pulse_tick();
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        @(negedge clk);
        n_cmp++; if ({chipsel, readstrobe, writestrobe} !== 3'b000) begin n_bad++;
            $display("FAIL reset_strobes: got %b want 000", {chipsel, readstrobe, writestrobe}); end
        n_cmp++; if ({dir_out, dato_out} !== 16'h0000) begin n_bad++;
            $display("FAIL reset_bus: got %h want 0000", {dir_out, dato_out}); end
        n_cmp++; if (snap !== 48'h0) begin n_bad++;
            $display("FAIL reset_snapshot: got %h want 0", snap); end
        n_cmp++; if ({valido, ocupado, wr_ack, error} !== 4'b0000) begin n_bad++;
            $display("FAIL reset_flags: got %b want 0000", {valido, ocupado, wr_ack, error}); end
        @(posedge clk); #1 reset = 1'b0;
        idle(2);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_scan();
        logic [47:0] expv;
        expv = 48'h455923311216;
        load_chip(expv);
        clear_log();
        pulse_tick();
        idle(60);
        n_cmp++; if (valq.size() !== 1) begin n_bad++;
            $display("FAIL scan_valido_count: got %0d want 1", valq.size()); end
        n_cmp++; if (evq.size() !== 6) begin n_bad++;
            $display("FAIL scan_strobe_count: got %0d want 6", evq.size()); end
        for (int k = 0; k < 6 && k < evq.size(); k++) begin
            n_cmp++; if (evq[k].wr || evq[k].a !== 8'(8'h21 + k)) begin n_bad++;
                $display("FAIL scan_addr%0d: got wr=%0d a=%h want read a=%h", k, evq[k].wr, evq[k].a, 8'(8'h21 + k)); end
            if (k > 0) begin
                n_cmp++; if (evq[k].t - evq[k-1].t !== REG_LAT) begin n_bad++;
                    $display("FAIL scan_spacing%0d: got %0d want %0d", k, evq[k].t - evq[k-1].t, REG_LAT); end
            end
        end
        if (valq.size() > 0 && evq.size() > 0) begin
            n_cmp++; if (valq[0] - evq[0].t !== SCAN_LAT) begin n_bad++;
                $display("FAIL scan_latency: got %0d want %0d", valq[0] - evq[0].t, SCAN_LAT); end
        end
        n_cmp++; if (snap !== expv) begin n_bad++;
            $display("FAIL scan_snapshot: got %h want %h", snap, expv); end
        n_cmp++; if (ocupado !== 1'b0) begin n_bad++;
            $display("FAIL scan_idle: got ocupado=%b want 0", ocupado); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_write_tick();
        load_chip(48'h011208150307);
        clear_log();
        @(posedge clk); #1 tick = 1'b1; wr_req = 1'b1; wr_dir = 8'h22; wr_dato = 8'h30;
        @(posedge clk); #1 tick = 1'b0; wr_req = 1'b0; wr_dir = 8'h00; wr_dato = 8'h00;
        idle(80);
        n_cmp++; if (evq.size() !== 7) begin n_bad++;
            $display("FAIL wt_strobe_count: got %0d want 7", evq.size()); end
        if (evq.size() > 0) begin
            n_cmp++; if (!evq[0].wr || evq[0].a !== 8'h22 || evq[0].d !== 8'h30) begin n_bad++;
                $display("FAIL wt_first_write: got wr=%0d a=%h d=%h want wr=1 a=22 d=30", evq[0].wr, evq[0].a, evq[0].d); end
            n_cmp++; if (ackq.size() !== 1 || ackq[0] - evq[0].t !== 5) begin n_bad++;
                $display("FAIL wt_ack: got count=%0d delay=%0d want 1 / 5", ackq.size(), ackq.size() ? ackq[0] - evq[0].t : -1); end
        end
        if (evq.size() > 1) begin
            n_cmp++; if (evq[1].wr || evq[1].a !== 8'h21) begin n_bad++;
                $display("FAIL wt_scan_start: got wr=%0d a=%h want read a=21", evq[1].wr, evq[1].a); end
        end
        n_cmp++; if (valq.size() !== 1 || snap !== chip_regs()) begin n_bad++;
            $display("FAIL wt_snapshot: got n=%0d %h want 1 %h", valq.size(), snap, chip_regs()); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_multi_tick();
        load_chip(48'h300917280599);
        clear_log();
        pulse_tick();
        idle(8);  pulse_tick();
        idle(5);  pulse_tick();
        idle(5);  pulse_tick();
        idle(120);
        n_cmp++; if (valq.size() !== 2) begin n_bad++;
            $display("FAIL mt_valido_count: got %0d want 2", valq.size()); end
        n_cmp++; if (evq.size() !== 12) begin n_bad++;
            $display("FAIL mt_strobe_count: got %0d want 12", evq.size()); end
        if (evq.size() > 6) begin
            n_cmp++; if (evq[6].a !== 8'h21) begin n_bad++;
                $display("FAIL mt_restart_addr: got %h want 21", evq[6].a); end
        end
        n_cmp++; if (snap !== chip_regs()) begin n_bad++;
            $display("FAIL mt_snapshot: got %h want %h", snap, chip_regs()); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid();
        int  budget;
        load_chip(48'h214611190824);
        clear_log();
        pulse_tick();
        budget = 0;
        while (evq.size() < 4 && budget < 100) begin
            @(posedge clk); budget++;
        end
        n_cmp++; if (evq.size() < 4) begin n_bad++;
            $display("FAIL rm_reach_reg3: got %0d strobes want 4 within bound", evq.size()); end
        @(negedge clk); #2 reset = 1'b1;
        #1;
        n_cmp++; if ({chipsel, readstrobe, writestrobe, ocupado, valido, dir_out, snap} !== 61'h0) begin n_bad++;
            $display("FAIL rm_async_clear: got cs=%b oc=%b dir=%h snap=%h want all 0", chipsel, ocupado, dir_out, snap); end
        @(posedge clk); #1 reset = 1'b0;
        idle(50);
        n_cmp++; if (valq.size() !== 0) begin n_bad++;
            $display("FAIL rm_no_commit: got %0d valido pulses want 0", valq.size()); end
        clear_log();
        pulse_tick();
        idle(60);
        n_cmp++; if (evq.size() === 0 || evq[0].a !== 8'h21) begin n_bad++;
            $display("FAIL rm_restart: got n=%0d a=%h want a=21", evq.size(), evq.size() ? evq[0].a : 8'hxx); end
        n_cmp++; if (valq.size() !== 1 || snap !== chip_regs()) begin n_bad++;
            $display("FAIL rm_snapshot: got n=%0d %h want 1 %h", valq.size(), snap, chip_regs()); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_random();
        logic       pend;
        logic [7:0] pdir, pdat;
        int         nstrobe, nack, nval, nticks;
        for (int it = 0; it < 8; it++) begin
            load_chip({rand_bcd(0, 59), rand_bcd(0, 59), rand_bcd(0, 23),
                       rand_bcd(1, 31), rand_bcd(1, 12), rand_bcd(0, 99)});
            pend = 1'b0; pdir = 8'h00; pdat = 8'h00;
            nstrobe = 0; nack = 0; nval = 0; nticks = 0;
            for (int c = 0; c < 150; c++) begin
                @(posedge clk); #1;
                tick    = (c < 50) && ($urandom_range(19, 0) == 0);
                wr_req  = (c < 50) && ($urandom_range(24, 0) == 0);
                wr_dir  = 8'($urandom);
                wr_dato = 8'($urandom);
                if (tick) nticks++;
                @(negedge clk);
                if (writestrobe) begin
                    nstrobe++;
                    n_cmp++; if (!pend || dir_out !== pdir || dato_out !== pdat) begin n_bad++;
                        $display("FAIL rnd_write%0d: got pend=%b a=%h d=%h want a=%h d=%h", it, pend, dir_out, dato_out, pdir, pdat); end
                    pend = 1'b0;
                end
                if (wr_req) begin pend = 1'b1; pdir = wr_dir; pdat = wr_dato; end
                if (wr_ack) nack++;
                if (valido) begin
                    nval++;
                    n_cmp++; if (snap !== chip_regs()) begin n_bad++;
                        $display("FAIL rnd_snapshot%0d: got %h want %h", it, snap, chip_regs()); end
                end
            end
            tick = 1'b0; wr_req = 1'b0;
            n_cmp++; if (pend || nack !== nstrobe || ocupado !== 1'b0) begin n_bad++;
                $display("FAIL rnd_drain%0d: got pend=%b acks=%0d strobes=%0d oc=%b want 0 equal 0", it, pend, nack, nstrobe, ocupado); end
            n_cmp++; if ((nticks > 0) !== (nval > 0) || nval > nticks) begin n_bad++;
                $display("FAIL rnd_scans%0d: got %0d scans for %0d ticks", it, nval, nticks); end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_bcd();
        logic [47:0] good_a, good_b;
        good_a = 48'h102009140623;
        good_b = 48'h590123311224;
        load_chip(good_a);
        clear_log();
        pulse_tick(); idle(60);
        n_cmp++; if (snap !== good_a || error !== 1'b0) begin n_bad++;
            $display("FAIL bcd_good_first: got %h err=%b want %h err=0", snap, error, good_a); end
        rtc_mem[8'h22] = 8'h5A;
        clear_log();
        pulse_tick(); idle(60);
`ifdef BCD_CHECK_EN
        n_cmp++; if (valq.size() !== 0 || snap !== good_a || error !== 1'b1) begin n_bad++;
            $display("FAIL bcd_reject: got n=%0d %h err=%b want 0 %h err=1", valq.size(), snap, error, good_a); end
        load_chip(good_b);
        clear_log();
        pulse_tick(); idle(60);
        n_cmp++; if (valq.size() !== 1 || snap !== good_b || error !== 1'b1) begin n_bad++;
            $display("FAIL bcd_sticky: got n=%0d %h err=%b want 1 %h err=1", valq.size(), snap, error, good_b); end
`else
        n_cmp++; if (valq.size() !== 1 || snap !== chip_regs() || error !== 1'b0) begin n_bad++;
            $display("FAIL bcd_unchecked: got n=%0d %h err=%b want 1 %h err=0", valq.size(), snap, error, chip_regs()); end
        load_chip(good_b);
`endif
    endtask

    initial begin
        for (int k = 0; k < 256; k++) rtc_mem[k] = 8'h00;
        test_reset();
        test_scan();
        test_write_tick();
        test_multi_tick();
        test_reset_mid();
        test_random();
        test_bcd();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
